dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter FW, default 20, which sets the frequency word width and matches the wave_freq width.
REQ-002 The block SHALL have parameter DW, default 24, which sets the dwell counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a level sampled each cycle that requests a sweep.
REQ-006 The block SHALL have port stop, input, 1 bit: a level sampled each cycle that aborts a sweep.
REQ-007 The block SHALL have port mode, input, 2 bits: 0 = single, 1 = repeat (sawtooth), 2 = triangle, 3 = reserved and treated as single.
REQ-008 The block SHALL have ports f_start, f_stop and f_step, each input, FW bits: the sweep lower bound, upper bound and increment.
REQ-009 The block SHALL have port dwell, input, DW bits: the number of clock cycles each frequency is held.
REQ-010 The block SHALL have port phase_wrap, input, 1 bit: a one-cycle pulse from the wave generator when its phase accumulator wraps.
REQ-011 The block SHALL have port wave_freq, output, FW bits: the frequency word driven to the wave generator and display.
REQ-012 The block SHALL have port freq_upd, output, 1 bit: a one-cycle pulse in the cycle wave_freq takes a new value.
REQ-013 The block SHALL have ports busy, done and cfg_err, each output, 1 bit: sweep active; one-cycle completion pulse; one-cycle rejected-start pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, DWELL, WAIT_WRAP and FINISH.
REQ-015 In IDLE, the block SHALL accept start only when stop=0; stop wins on simultaneous assertion.
REQ-016 When start is accepted, the block SHALL latch mode, f_start, f_stop, f_step and dwell; later input changes SHALL have no effect until the next start.
REQ-017 If start is accepted with f_start > f_stop, the block SHALL pulse cfg_err for 1 cycle the next cycle, remain in IDLE, and leave wave_freq unchanged.
REQ-018 On a valid start, the cycle after start the block SHALL set wave_freq=f_start, pulse freq_upd, set busy=1, set direction to up, load the dwell counter with max(dwell,1), and enter DWELL.
REQ-019 In DWELL, the counter SHALL decrement by 1 per cycle; on reaching 1 the FSM SHALL enter WAIT_WRAP, so each frequency is held for at least max(dwell,1) cycles.
REQ-020 In WAIT_WRAP, the block SHALL wait for phase_wrap=1; the next wave_freq SHALL appear, with freq_upd, the cycle after that phase_wrap, and the counter SHALL reload and the FSM SHALL return to DWELL (phase-continuous update).
REQ-021 Next-value arithmetic SHALL be done at FW+1 bits: up = cur+f_step, clamped to f_stop if greater; down = cur-f_step, clamped to f_start if below f_start (no wrap-around).
REQ-022 When wave_freq=f_stop at the end of a dwell in single mode, the FSM SHALL enter FINISH with no further update; FINISH SHALL pulse done for 1 cycle, drop busy, and return to IDLE, with wave_freq held.
REQ-023 When wave_freq=f_stop at the end of a dwell in repeat mode, the next value SHALL be f_start (via WAIT_WRAP), repeating indefinitely.
REQ-024 In triangle mode, direction SHALL flip at f_stop (next = down step) and at f_start (next = up step); the endpoints SHALL not be repeated.
REQ-025 When f_step=0 or f_start=f_stop, the block SHALL hold f_start indefinitely in repeat/triangle modes; in single mode it SHALL finish after the first dwell.
REQ-026 When stop=1 in any non-IDLE state, the block SHALL enter IDLE the next cycle with busy=0, no done, no freq_upd, and wave_freq held.
REQ-027 The block SHALL ignore start while busy=1.
REQ-028 The block SHALL keep freq_upd, done and cfg_err mutually exclusive, each at most one cycle wide.

Reset
REQ-029 While rst_n=0, the block SHALL set state IDLE, wave_freq=0, freq_upd=0, busy=0, done=0, cfg_err=0, counter=0, and direction to up, asynchronously.
REQ-030 After rst_n is released, the block SHALL not act on start until the first rising clk edge; a reset mid-sweep SHALL abort it with no done.

Verification
REQ-031 Single sweep: f_start=100, f_stop=130, f_step=10, dwell=4, phase_wrap every 3 cycles -> wave_freq 100,110,120,130, each held >=4 cycles, updates 1 cycle after a phase_wrap, then a done pulse and busy=0.
REQ-032 Clamp: f_start=0, f_stop=25, f_step=10, single mode -> wave_freq 0,10,20,25, then done.
REQ-033 Triangle: f_start=10, f_stop=30, f_step=10 -> wave_freq 10,20,30,20,10,20... until stop, after which busy=0 one cycle later and wave_freq is frozen.
REQ-034 Bad config: f_start=50, f_stop=40, start -> one cfg_err pulse, busy stays 0, no freq_upd; start and stop asserted together in IDLE -> nothing happens.
REQ-035 Reset mid-sweep: assert rst_n=0 while in WAIT_WRAP -> immediately wave_freq=0 and busy=0; no done; a new start after release begins at f_start.
REQ-036 dwell=0 with repeat mode, f_start=5, f_stop=6, f_step=1 -> each value is held >=1 cycle and the sequence is 5,6,5,6... gated by phase_wrap.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency sweep sequencer for a DDS wave generator. A sweep is configured
// with a lower bound, an upper bound, a step and a dwell time. Each frequency
// is held for at least max(dwell,1) cycles. After that the next frequency is
// applied only in the cycle after the generator's phase accumulator wraps, so
// the output waveform stays phase-continuous.
//
// Modes: 0 = single sweep, 1 = repeat (sawtooth), 2 = triangle,
//        3 = treated as single.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       level; requests a sweep while idle (stop has priority)
//   stop        level; aborts an active sweep, wave_freq is frozen
//   mode        sweep mode, latched at start
//   f_start     sweep lower bound, latched at start
//   f_stop      sweep upper bound, latched at start
//   f_step      sweep increment, latched at start
//   dwell       minimum cycles per frequency, latched at start
//   phase_wrap  one-cycle pulse from the generator on accumulator wrap
//   wave_freq   frequency word to the generator and display
//   freq_upd    one-cycle pulse in the cycle wave_freq takes a new value
//   busy        sweep active
//   done        one-cycle pulse when a single sweep completes
//   cfg_err     one-cycle pulse when a start is rejected (f_start > f_stop)
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FW = 20,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic          phase_wrap,
    output logic [FW-1:0] wave_freq,
    output logic          freq_upd,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DWELL     = 2'd1;
    localparam logic [1:0] S_WAIT_WRAP = 2'd2;
    localparam logic [1:0] S_FINISH    = 2'd3;

    localparam logic [1:0] M_REPEAT    = 2'd1;
    localparam logic [1:0] M_TRIANGLE  = 2'd2;

    // Upward step, saturating at the upper bound instead of wrapping.
    function automatic logic [FW-1:0] sat_up(input logic [FW-1:0] cur,
                                             input logic [FW-1:0] inc,
                                             input logic [FW-1:0] hi);
        logic [FW:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (sum > {1'b0, hi})
            return hi;
        return sum[FW-1:0];
    endfunction

    // Downward step, saturating at the lower bound; a negative difference
    // is also caught here, so cur < inc never wraps to a large value.
    function automatic logic [FW-1:0] sat_down(input logic [FW-1:0] cur,
                                               input logic [FW-1:0] dec,
                                               input logic [FW-1:0] lo);
        logic signed [FW+1:0] diff;
        diff = $signed({2'b00, cur}) - $signed({2'b00, dec});
        if (diff < $signed({2'b00, lo}))
            return lo;
        return diff[FW-1:0];
    endfunction

    logic [1:0]    state;
    logic [DW-1:0] cnt;
    logic          dir_up;

    // Sweep configuration captured on an accepted start
    logic [1:0]    mode_q;
    logic [FW-1:0] f_lo_q;
    logic [FW-1:0] f_hi_q;
    logic [FW-1:0] f_inc_q;
    logic [DW-1:0] dwell_q;

    logic          accept;
    logic [DW-1:0] dwell_min1;
    logic [FW-1:0] nxt_freq;
    logic          nxt_dir;
    logic          single_end;

    assign accept     = (state == S_IDLE) && start && !stop;
    assign dwell_min1 = (dwell == '0) ? DW'(1) : dwell;

    // Configuration is plain data: loaded on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q  <= mode;
            f_lo_q  <= f_start;
            f_hi_q  <= f_stop;
            f_inc_q <= f_step;
            dwell_q <= dwell_min1;
        end
    end

    // Next frequency and direction, applied on the next phase wrap.
    always_comb begin
        nxt_freq = wave_freq;
        nxt_dir  = dir_up;
        case (mode_q)
            M_REPEAT: begin
                if (wave_freq >= f_hi_q)
                    nxt_freq = f_lo_q;
                else
                    nxt_freq = sat_up(wave_freq, f_inc_q, f_hi_q);
            end
            M_TRIANGLE: begin
                if (dir_up) begin
                    if (wave_freq >= f_hi_q) begin
                        nxt_freq = sat_down(wave_freq, f_inc_q, f_lo_q);
                        nxt_dir  = 1'b0;
                    end else begin
                        nxt_freq = sat_up(wave_freq, f_inc_q, f_hi_q);
                    end
                end else begin
                    if (wave_freq <= f_lo_q) begin
                        nxt_freq = sat_up(wave_freq, f_inc_q, f_hi_q);
                        nxt_dir  = 1'b1;
                    end else begin
                        nxt_freq = sat_down(wave_freq, f_inc_q, f_lo_q);
                    end
                end
            end
            default: nxt_freq = sat_up(wave_freq, f_inc_q, f_hi_q);
        endcase
    end

    // A zero step in single mode can never reach the upper bound, so it
    // ends after the first dwell as well.
    assign single_end = (mode_q != M_REPEAT) && (mode_q != M_TRIANGLE) &&
                        ((wave_freq >= f_hi_q) || (f_inc_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wave_freq <= '0;
            freq_upd  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            cnt       <= '0;
            dir_up    <= 1'b1;
        end else begin
            freq_upd <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            if (state != S_IDLE && stop) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (f_start > f_stop) begin
                                cfg_err <= 1'b1;
                            end else begin
                                wave_freq <= f_start;
                                freq_upd  <= 1'b1;
                                busy      <= 1'b1;
                                dir_up    <= 1'b1;
                                cnt       <= dwell_min1;
                                state     <= S_DWELL;
                            end
                        end
                    end
                    S_DWELL: begin
                        if (cnt <= DW'(1))
                            state <= single_end ? S_FINISH : S_WAIT_WRAP;
                        else
                            cnt <= cnt - DW'(1);
                    end
                    S_WAIT_WRAP: begin
                        if (phase_wrap) begin
                            wave_freq <= nxt_freq;
                            // degenerate sweeps re-apply the same word silently
                            freq_upd  <= (nxt_freq != wave_freq);
                            dir_up    <= nxt_dir;
                            cnt       <= dwell_q;
                            state     <= S_DWELL;
                        end
                    end
                    default: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

    localparam int FW = 20;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic          phase_wrap;
    logic [FW-1:0] wave_freq;
    logic          freq_upd;
    logic          busy;
    logic          done;
    logic          cfg_err;

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .phase_wrap (phase_wrap),
        .wave_freq  (wave_freq),
        .freq_upd   (freq_upd),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int seq[$];
    int done_cnt;
    int hold_bad;
    int wrap_bad;
    int excl_bad;
    bit timed_out;

    // Phase-wrap source: one-cycle pulse every wrap_period cycles, 0 = off.
    // Changes 2 time units after the edge, away from the sampling point.
    int wrap_period = 0;
    int wrap_cnt    = 0;
    initial begin
        phase_wrap = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (wrap_period == 0) begin
                phase_wrap = 1'b0;
                wrap_cnt   = 0;
            end else begin
                wrap_cnt++;
                phase_wrap = (wrap_cnt >= wrap_period);
                if (phase_wrap) wrap_cnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int m, input int fs, input int fe, input int st, input int dw);
        mode    = m[1:0];
        f_start = fs[FW-1:0];
        f_stop  = fe[FW-1:0];
        f_step  = st[FW-1:0];
        dwell   = dw[DW-1:0];
    endtask

    // Observe the sweep after start has been raised: collects every new
    // frequency word and counts protocol violations along the way.
    task automatic watch(input int max_cycles, input bit until_done,
                         input int min_hold, input bit hold_start);
        int  hold;
        bit  first;
        seq.delete();
        done_cnt  = 0;
        hold_bad  = 0;
        wrap_bad  = 0;
        excl_bad  = 0;
        timed_out = until_done;
        hold      = 0;
        first     = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (i == 0) begin
                if (hold_start) set_cfg(2, 7, 9999, 1, 1);
                else            start = 1'b0;
            end
            hold++;
            if (freq_upd) begin
                if (!first) begin
                    if (hold < min_hold) hold_bad++;
                    if (!phase_wrap)     wrap_bad++;
                end
                seq.push_back(int'(wave_freq));
                hold  = 0;
                first = 1'b0;
            end
            if ((int'(freq_upd) + int'(done) + int'(cfg_err)) > 1) excl_bad++;
            if (done) begin
                done_cnt++;
                if (until_done) begin
                    timed_out = 1'b0;
                    start     = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (wave_freq !== 0) $display("FAIL reset_wave_freq: got %0d expected 0", wave_freq); else n_pass++;
        n_checks++; if (freq_upd !== 1'b0) $display("FAIL reset_freq_upd: got %0b expected 0", freq_upd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else n_pass++;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %0b expected 0", cfg_err); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single;
        int exp_seq[4] = '{100, 110, 120, 130};
        wrap_period = 3;
        set_cfg(0, 100, 130, 10, 4);
        start = 1'b1;
        // start kept high and inputs scrambled during the sweep
        watch(300, 1'b1, 4, 1'b1);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL single_timeout: got %0b expected 0", timed_out); else n_pass++;
        n_checks++; if (seq.size() !== 4) $display("FAIL single_len: got %0d expected 4", seq.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (((i < seq.size()) ? seq[i] : -1) !== exp_seq[i])
                $display("FAIL single_val%0d: got %0d expected %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
            else n_pass++;
        end
        n_checks++; if (hold_bad !== 0) $display("FAIL single_hold: got %0d short holds expected 0", hold_bad); else n_pass++;
        n_checks++; if (wrap_bad !== 0) $display("FAIL single_wrap_sync: got %0d unsynced updates expected 0", wrap_bad); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_at_done: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (excl_bad !== 0) $display("FAIL single_exclusive: got %0d overlaps expected 0", excl_bad); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL single_done_width: got %0b expected 0", done); else n_pass++;
        n_checks++; if (wave_freq !== 130) $display("FAIL single_hold_final: got %0d expected 130", wave_freq); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_no_restart: got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_clamp;
        int exp_seq[4] = '{0, 10, 20, 25};
        wrap_period = 3;
        set_cfg(0, 0, 25, 10, 2);
        start = 1'b1;
        watch(300, 1'b1, 2, 1'b0);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL clamp_timeout: got %0b expected 0", timed_out); else n_pass++;
        n_checks++; if (seq.size() !== 4) $display("FAIL clamp_len: got %0d expected 4", seq.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (((i < seq.size()) ? seq[i] : -1) !== exp_seq[i])
                $display("FAIL clamp_val%0d: got %0d expected %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL clamp_done: got %0d pulses expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_triangle;
        int exp_seq[7] = '{10, 20, 30, 20, 10, 20, 30};
        int frozen;
        int upd_after;
        bit moved;
        wrap_period = 4;
        set_cfg(2, 10, 30, 10, 2);
        start = 1'b1;
        watch(60, 1'b0, 2, 1'b0);
        n_checks++; if (seq.size() < 7) $display("FAIL tri_len: got %0d expected >= 7", seq.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (((i < seq.size()) ? seq[i] : -1) !== exp_seq[i])
                $display("FAIL tri_val%0d: got %0d expected %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
            else n_pass++;
        end
        n_checks++; if (wrap_bad !== 0) $display("FAIL tri_wrap_sync: got %0d unsynced updates expected 0", wrap_bad); else n_pass++;
        n_checks++; if (done_cnt !== 0) $display("FAIL tri_no_done: got %0d pulses expected 0", done_cnt); else n_pass++;
        frozen = int'(wave_freq);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL tri_stop_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL tri_stop_done: got %0b expected 0", done); else n_pass++;
        n_checks++; if (freq_upd !== 1'b0) $display("FAIL tri_stop_upd: got %0b expected 0", freq_upd); else n_pass++;
        upd_after = 0;
        moved     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (freq_upd) upd_after++;
            if (int'(wave_freq) != frozen) moved = 1'b1;
        end
        n_checks++; if (upd_after !== 0) $display("FAIL tri_frozen_upd: got %0d updates expected 0", upd_after); else n_pass++;
        n_checks++; if (moved !== 1'b0) $display("FAIL tri_frozen_freq: got %0d expected %0d", wave_freq, frozen); else n_pass++;
    endtask

    task automatic test_bad_cfg;
        int prev;
        wrap_period = 0;
        prev = int'(wave_freq);
        set_cfg(0, 50, 40, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (cfg_err !== 1'b1) $display("FAIL bad_cfg_err: got %0b expected 1", cfg_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL bad_cfg_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (freq_upd !== 1'b0) $display("FAIL bad_cfg_upd: got %0b expected 0", freq_upd); else n_pass++;
        n_checks++; if (wave_freq !== prev[FW-1:0]) $display("FAIL bad_cfg_freq: got %0d expected %0d", wave_freq, prev); else n_pass++;
        tick();
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL bad_cfg_width: got %0b expected 0", cfg_err); else n_pass++;
        set_cfg(0, 10, 20, 5, 1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        n_checks++; if (freq_upd !== 1'b0) $display("FAIL start_stop_upd: got %0b expected 0", freq_upd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL start_stop_busy: got %0b expected 0", busy); else n_pass++;
        set_cfg(0, 50, 40, 1, 1);
        tick();
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL start_stop_cfg_err: got %0b expected 0", cfg_err); else n_pass++;
        start = 1'b0;
        stop  = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        wrap_period = 0;
        set_cfg(0, 100, 200, 10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (wave_freq !== 100) $display("FAIL rmid_first: got %0d expected 100", wave_freq); else n_pass++;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_wait: got %0b expected 1", busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (wave_freq !== 0) $display("FAIL rmid_async_freq: got %0d expected 0", wave_freq); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_async_busy: got %0b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL rmid_no_done: got %0b expected 0", done); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL rmid_no_done_release: got %0b expected 0", done); else n_pass++;
        wrap_period = 3;
        set_cfg(0, 100, 120, 10, 2);
        start = 1'b1;
        watch(300, 1'b1, 2, 1'b0);
        n_checks++; if (((seq.size() > 0) ? seq[0] : -1) !== 100) $display("FAIL rmid_restart: got %0d expected 100", (seq.size() > 0) ? seq[0] : -1); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL rmid_restart_done: got %0d pulses expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_dwell0_repeat;
        int exp_seq[6] = '{5, 6, 5, 6, 5, 6};
        wrap_period = 2;
        set_cfg(1, 5, 6, 1, 0);
        start = 1'b1;
        watch(40, 1'b0, 1, 1'b0);
        n_checks++; if (seq.size() < 6) $display("FAIL rep_len: got %0d expected >= 6", seq.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (((i < seq.size()) ? seq[i] : -1) !== exp_seq[i])
                $display("FAIL rep_val%0d: got %0d expected %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
            else n_pass++;
        end
        n_checks++; if (wrap_bad !== 0) $display("FAIL rep_wrap_sync: got %0d unsynced updates expected 0", wrap_bad); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rep_busy: got %0b expected 1", busy); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rep_stop_busy: got %0b expected 0", busy); else n_pass++;
    endtask

    initial begin
        start = 1'b0;
        stop  = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_clamp();
        test_triangle();
        test_bad_cfg();
        test_reset_mid();
        test_dwell0_repeat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
